cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
Multi-cycle fetch/decode/execute/write-back sequencer for the 6-bit CPU. It fetches a 12-bit instruction as two 6-bit words over a ready-handshaked memory port and latches it into an instruction register. It decodes the opcode and register fields and drives the ALU op and register-file write enable. It sits directly upstream of the 3-bit 2:1 destination-address mux: rd feeds mux input i0, rt feeds i1, and dst_sel drives the mux select.

Parameters:
DATA_W, 6, memory word / datapath width
OP_W, 3, opcode width
RA_W, 3, register-address field width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_data  in  DATA_W  instruction word from program memory
mem_ready  in  1  memory has valid mem_data this cycle
mem_rd  out  1  fetch request
pc_inc  out  1  one-cycle PC increment strobe
rd  out  RA_W  ir[8:6], to dest mux i0
rs  out  RA_W  ir[5:3], register-file read port A
rt  out  RA_W  ir[2:0], to dest mux i1 and read port B
imm  out  RA_W  ir[8:6], zero-extended by datapath for ADDI
dst_sel  out  1  dest mux select: 0 = rd, 1 = rt
alu_op  out  OP_W  ALU operation (equals opcode)
reg_we  out  1  register-file write enable
instr_done  out  1  one-cycle pulse at instruction retirement
halted  out  1  core halted

Behaviour:
- Instruction format: ir[11:9] = opcode, ir[8:6] = rd/imm, ir[5:3] = rs, ir[2:0] = rt. The first fetched word is ir[11:6]; the second is ir[5:0].
- Opcodes:
  - 000 NOP
  - 001 ADD rd=rs+rt
  - 010 SUB rd=rs-rt
  - 011 AND rd=rs&rt
  - 100 OR rd=rs|rt
  - 101 MOV rd=rs
  - 110 ADDI rt=rs+imm
  - 111 HALT
- States: FETCH_HI, FETCH_LO, DECODE, EXEC, WB, HALT.
- Reset (asynchronous, immediate, including mid-instruction):
  - state=FETCH_HI, ir=0, dst_sel=0, alu_op=0, reg_we=0, pc_inc=0, instr_done=0, halted=0.
  - mem_rd=1, because it is decoded from state.
- mem_rd = 1 in FETCH_HI and FETCH_LO, 0 otherwise.
- FETCH_HI: on a clk edge with mem_ready=1, load ir[11:6]<=mem_data and go to FETCH_LO. Otherwise hold. Wait stalls are unbounded.
- FETCH_LO: same handshake, load ir[5:0] and go to DECODE.
- pc_inc = mem_rd & mem_ready, combinational. Exactly one pulse per accepted word.
- DECODE (1 cycle):
  - register dst_sel=1 for ADDI, else 0; register alu_op=opcode.
  - HALT opcode: go to HALT. Otherwise go to EXEC.
- EXEC (1 cycle):
  - NOP: pulse instr_done and go to FETCH_HI.
  - Other opcodes: go to WB.
- WB (1 cycle): reg_we=1 and instr_done=1, then go to FETCH_HI.
- HALT: halted=1, mem_rd=0, reg_we=0. Only rst exits.
- dst_sel, alu_op and rd/rs/rt/imm are stable from the cycle after DECODE through WB. The downstream mux output is therefore settled for the whole reg_we cycle.
- Latency with mem_ready tied high:
  - 5 cycles for a writing instruction;
  - 4 cycles for NOP;
  - HALT asserts halted 3 cycles after the fetch starts.
- reg_we is never asserted outside WB.
- A mem_ready that stays high across a state change loads each half exactly once.
- An X or unused mem_ready outside fetch states is ignored.

Decomposition:
- Package cpu_pkg holds:
  - DATA_W, OP_W, RA_W localparams;
  - opcode constants OP_NOP … OP_HALT;
  - state encoding ST_FETCH_HI … ST_HALT, 3-bit;
  - the DST_RD=0 / DST_RT=1 select constants shared with the mux instance.
- One combinational sub-module, cpu_instr_decode: opcode → {dst_sel, writes_reg, is_halt}. The FSM and instruction register stay in cpu_control_sequencer.

Test Plan:
- rst pulse, then release with mem_ready=1: mem_rd=1, halted=0, reg_we=0, ir=0 at the first edge after reset.
- ADD r1=r2+r3, fed as words 6'b001001, 6'b010011 with mem_ready=1: DECODE sees ir=12'h253; dst_sel=0, rd=1, alu_op=001; reg_we=1 in cycle 5 only; 2 pc_inc pulses.
- ADDI r3=r2+5, fed as words 6'b110101, 6'b010011: dst_sel=1, rt=3, imm=5; reg_we in cycle 5.
- Same ADD with mem_ready low for 3 cycles before each word: state holds; pc_inc=0 while stalled; exactly 2 pc_inc pulses total; reg_we at cycle 11.
- NOP then HALT, fed as 6'b000000, 6'b000000, 6'b111000, 6'b000000: instr_done after 4 cycles, no reg_we; halted=1 and mem_rd=0 permanently until rst.
- Assert rst during WB of an ADD: reg_we drops in the same cycle (async); FSM restarts in FETCH_HI with ir=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 6-bit CPU control path.
// Opcodes, sequencer states and destination-mux select codes.
package cpu_pkg;

    localparam int DATA_W = 6;
    localparam int OP_W   = 3;
    localparam int RA_W   = 3;
    localparam int IR_W   = 2 * DATA_W;

    localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
    localparam logic [OP_W-1:0] OP_AND  = 3'd3;
    localparam logic [OP_W-1:0] OP_OR   = 3'd4;
    localparam logic [OP_W-1:0] OP_MOV  = 3'd5;
    localparam logic [OP_W-1:0] OP_ADDI = 3'd6;
    localparam logic [OP_W-1:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH_HI = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WB       = 3'd4,
        ST_HALT     = 3'd5
    } state_e;

    localparam logic DST_RD = 1'b0;
    localparam logic DST_RT = 1'b1;

endpackage

// File: rtl/cpu_instr_decode.sv
// Opcode classifier: destination select, write-back need, halt.
// Purely combinational; the sequencer registers what it needs.
module cpu_instr_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] opcode_i,
    output logic            dst_sel_o,
    output logic            writes_reg_o,
    output logic            is_halt_o
);

    always_comb begin
        dst_sel_o    = (opcode_i == OP_ADDI) ? DST_RT : DST_RD;
        writes_reg_o = (opcode_i != OP_NOP) && (opcode_i != OP_HALT);
        is_halt_o    = (opcode_i == OP_HALT);
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer.
// Fetches a 12-bit instruction as two handshaked 6-bit words.
module cpu_control_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic              mem_rd,
    output logic              pc_inc,
    output logic [RA_W-1:0]   rd,
    output logic [RA_W-1:0]   rs,
    output logic [RA_W-1:0]   rt,
    output logic [RA_W-1:0]   imm,
    output logic              dst_sel,
    output logic [OP_W-1:0]   alu_op,
    output logic              reg_we,
    output logic              instr_done,
    output logic              halted
);

    state_e          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            dst_sel_q, dst_sel_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;

    logic dec_dst_sel;
    logic dec_writes;
    logic dec_halt;

    cpu_instr_decode u_dec (
        .opcode_i     (ir_q[11:9]),
        .dst_sel_o    (dec_dst_sel),
        .writes_reg_o (dec_writes),
        .is_halt_o    (dec_halt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH_HI;
            ir_q      <= '0;
            dst_sel_q <= DST_RD;
            alu_op_q  <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            dst_sel_q <= dst_sel_d;
            alu_op_q  <= alu_op_d;
        end
    end

    // Strobes are decoded from state so async reset clears them at once.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        dst_sel_d  = dst_sel_q;
        alu_op_d   = alu_op_q;
        mem_rd     = 1'b0;
        reg_we     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            ST_FETCH_HI: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_d[11:6] = mem_data;
                    state_d    = ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_d[5:0] = mem_data;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                dst_sel_d = dec_dst_sel;
                alu_op_d  = ir_q[11:9];
                state_d   = dec_halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_writes) begin
                    state_d = ST_WB;
                end else begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH_HI;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH_HI;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH_HI;
            end
        endcase
    end

    assign pc_inc  = mem_rd & mem_ready;
    assign rd      = ir_q[8:6];
    assign imm     = ir_q[8:6];
    assign rs      = ir_q[5:3];
    assign rt      = ir_q[2:0];
    assign dst_sel = dst_sel_q;
    assign alu_op  = alu_op_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Randomised self-checking bench for cpu_control_sequencer.
// A transaction-level timeline model predicts every cycle's outputs.
module tb_cpu_control_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  mem_data;
    logic        mem_ready;
    logic        mem_rd, pc_inc;
    logic [2:0]  rd, rs, rt, imm, alu_op;
    logic        dst_sel, reg_we, instr_done, halted;

    always #5 clk = ~clk;

    cpu_control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .pc_inc     (pc_inc),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .dst_sel    (dst_sel),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .instr_done (instr_done),
        .halted     (halted)
    );

    typedef struct {
        bit       mem_rd;
        bit       we;
        bit       done;
        bit       chk;
        bit       to_halt;
        bit [2:0] op;
        bit [2:0] f_rd;
        bit [2:0] f_rs;
        bit [2:0] f_rt;
    } exp_t;

    exp_t      fq[$];
    bit [5:0]  prog[$];
    bit        halted_m;
    bit        half;
    bit [11:0] ir_m;
    int        wi;
    int        st;
    int        cyc, we_cyc, done_cyc, halt_cyc;
    int        total = 0;
    int        bad = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push_instr(bit [2:0] op, bit [2:0] a,
                                       bit [2:0] b, bit [2:0] c);
        prog.push_back({op, a});
        prog.push_back({b, c});
    endfunction

    // Instruction accepted: lay out the cycles it will occupy.
    function automatic void schedule();
        exp_t d, x, w;
        bit [2:0] op;
        op = ir_m[11:9];
        d = '{default: '0};
        d.to_halt = (op == OP_HALT);
        fq.push_back(d);
        if (op != OP_HALT) begin
            x = '{default: '0};
            x.chk  = 1'b1;
            x.op   = op;
            x.f_rd = ir_m[8:6];
            x.f_rs = ir_m[5:3];
            x.f_rt = ir_m[2:0];
            x.done = (op == OP_NOP);
            fq.push_back(x);
            if (op != OP_NOP) begin
                w = x;
                w.we   = 1'b1;
                w.done = 1'b1;
                fq.push_back(w);
            end
        end
    endfunction

    // pct < 0 selects the fixed pattern: 3 idle cycles before each word.
    task automatic step(int pct);
        exp_t e;
        bit   fetching;
        bit   pc_e;
        @(negedge clk);
        cyc++;
        fetching = !halted_m && (fq.size() == 0);
        if (pct < 0) begin
            if (fetching) begin
                mem_ready = (st == 3);
                st = mem_ready ? 0 : st + 1;
            end else begin
                mem_ready = 1'($urandom);
            end
        end else begin
            mem_ready = ($urandom_range(99) < pct);
        end
        mem_data = (wi < prog.size()) ? prog[wi] : 6'($urandom);
        #1;
        e = '{default: '0};
        pc_e = 1'b0;
        if (fetching) begin
            e.mem_rd = 1'b1;
            pc_e = mem_ready;
        end else if (!halted_m) begin
            e = fq.pop_front();
        end
        check("mem_rd", mem_rd, e.mem_rd);
        check("pc_inc", pc_inc, pc_e);
        check("reg_we", reg_we, e.we);
        check("instr_done", instr_done, e.done);
        check("halted", halted, halted_m);
        if (e.chk) begin
            check("dst_sel", dst_sel, e.op == OP_ADDI);
            check("alu_op", alu_op, e.op);
            check("rd", rd, e.f_rd);
            check("rs", rs, e.f_rs);
            check("rt", rt, e.f_rt);
            check("imm", imm, e.f_rd);
            if (e.we)
                check("dest_addr", dst_sel ? rt : rd,
                      (e.op == OP_ADDI) ? e.f_rt : e.f_rd);
        end
        if (reg_we && we_cyc == 0) we_cyc = cyc;
        if (instr_done && done_cyc == 0) done_cyc = cyc;
        if (halted && halt_cyc == 0) halt_cyc = cyc;
        if (e.to_halt) halted_m = 1'b1;
        if (fetching && mem_ready) begin
            if (!half) ir_m[11:6] = mem_data;
            else ir_m[5:0] = mem_data;
            wi++;
            half = ~half;
            if (!half) schedule();
        end
    endtask

    task automatic run(int n, int pct);
        for (int i = 0; i < n; i++) step(pct);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("rst_mem_rd", mem_rd, 1);
        check("rst_halted", halted, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_done", instr_done, 0);
        check("rst_pc_inc", pc_inc, 0);
        check("rst_ir", {rd, rs, rt}, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_dst_sel", dst_sel, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fq.delete();
        prog.delete();
        halted_m = 1'b0;
        half = 1'b0;
        ir_m = '0;
        wi = 0;
        st = 0;
        cyc = 0;
        we_cyc = 0;
        done_cyc = 0;
        halt_cyc = 0;
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0;
        mem_data = '0;

        do_reset();
        push_instr(OP_ADD, 3'd1, 3'd2, 3'd3);
        run(8, 100);
        check("add_we_cycle", we_cyc, 5);

        do_reset();
        push_instr(OP_ADDI, 3'd5, 3'd2, 3'd3);
        run(8, 100);
        check("addi_we_cycle", we_cyc, 5);

        do_reset();
        push_instr(OP_ADD, 3'd1, 3'd2, 3'd3);
        run(14, -1);
        check("stall_we_cycle", we_cyc, 11);

        do_reset();
        push_instr(OP_NOP, 3'd0, 3'd0, 3'd0);
        push_instr(OP_HALT, 3'd0, 3'd0, 3'd0);
        run(20, 100);
        check("nop_done_cycle", done_cyc, 4);
        check("halt_cycle", halt_cyc, 8);
        check("nop_no_we", we_cyc, 0);

        do_reset();
        push_instr(OP_ADD, 3'd1, 3'd2, 3'd3);
        run(5, 100);
        check("wb_reached", we_cyc, 5);
        rst = 1'b1;
        #1;
        check("async_reg_we", reg_we, 0);
        check("async_done", instr_done, 0);
        check("async_mem_rd", mem_rd, 1);
        check("async_ir", {rd, rs, rt}, 0);
        check("async_alu_op", alu_op, 0);
        do_reset();
        push_instr(OP_ADDI, 3'd7, 3'd4, 3'd6);
        run(8, 100);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int k = 0; k < 30; k++)
                push_instr(3'($urandom_range(6)), 3'($urandom),
                           3'($urandom), 3'($urandom));
            push_instr(OP_HALT, 3'($urandom), 3'($urandom), 3'($urandom));
            run(700, 30 + 30 * r);
            check("rand_halted", halted, 1);
            check("rand_words", wi, prog.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
